// File: rtl/add_sub_seq.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_seq
// Description : Multi-cycle chunked adder/subtractor with valid/ready handshake
//               and Z/V/N flags under signed or unsigned semantics.
//               Optional output saturation on overflow: ADD_SUB_SEQ_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             z,
    output logic             v,
    output logic             n
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] c_last_cnt = CW'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_bad_cfg
            $error("add_sub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_sub;
    logic             r_sign;
    logic             r_amsb;
    logic             r_bmsb;
    logic             r_z;
    logic             r_v;
    logic             r_n;
    logic             r_out_valid;
    logic             r_in_ready;

    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_s_next;
    logic [WIDTH-1:0] w_s_out;
    logic             w_cout;
    logic             w_smsb;
    logic             w_z;
    logic             w_v;
    logic             w_n;

    // Operand registers shift right so the active chunk is always the low CHUNK bits.
    assign w_sum  = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
    assign w_cout = w_sum[CHUNK];

    generate
        if (NCHUNK == 1) begin : g_single
            assign w_s_next = w_sum[CHUNK-1:0];
        end else begin : g_multi
            assign w_s_next = {w_sum[CHUNK-1:0], r_s[WIDTH-1:CHUNK]};
        end
    endgenerate

    assign w_smsb = w_s_next[WIDTH-1];
    assign w_z    = (w_s_next == '0);

    always_comb begin
        w_v = 1'b0;
        w_n = 1'b0;
        if (r_sign) begin
            w_v = (r_amsb == r_bmsb) && (w_smsb != r_amsb);
            w_n = w_smsb ^ w_v;
        end else if (r_sub) begin
            w_v = ~w_cout;
            w_n = ~w_cout;
        end else begin
            w_v = w_cout;
            w_n = 1'b0;
        end
    end

    always_comb begin
        w_s_out = w_s_next;
`ifdef ADD_SUB_SEQ_SAT_EN
        if (w_v) begin
            if (r_sign)
                w_s_out = w_n ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            else if (r_sub)
                w_s_out = '0;
            else
                w_s_out = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_sub       <= 1'b0;
            r_sign      <= 1'b0;
            r_amsb      <= 1'b0;
            r_bmsb      <= 1'b0;
            r_z         <= 1'b0;
            r_v         <= 1'b0;
            r_n         <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= sub ? ~b : b;
                        r_sub      <= sub;
                        r_sign     <= sign;
                        r_amsb     <= a[WIDTH-1];
                        r_bmsb     <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        r_carry    <= sub;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_s     <= w_s_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_last_cnt) begin
                        r_s         <= w_s_out;
                        r_z         <= w_z;
                        r_v         <= w_v;
                        r_n         <= w_n;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign z         = r_z;
    assign v         = r_v;
    assign n         = r_n;

endmodule
`default_nettype wire
